// File: rtl/dbus_responder_pkg.sv
// Shared types and constants for the data-bus responder and its store-path helpers.
package dbus_responder_pkg;

  typedef logic [63:0] word_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'd0,
    MSIZE2 = 3'd1,
    MSIZE4 = 3'd2,
    MSIZE8 = 3'd3
  } msize_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } dbus_rsp_state_t;

  localparam int DBUS_MAX_LATENCY = 15;

  // Natural alignment for the legal sizes; any other size code is never aligned.
  function automatic logic size_aligned(input logic [2:0] addr_lo, input logic [2:0] size);
    logic ok;
    ok = 1'b0;
    case (size)
      MSIZE1:  ok = 1'b1;
      MSIZE2:  ok = (addr_lo[0] == 1'b0);
      MSIZE4:  ok = (addr_lo[1:0] == 2'b00);
      MSIZE8:  ok = (addr_lo == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dbus_responder_strobe_merge.sv
// Byte-lane merge: each strobed byte comes from the new word, the rest from the old word.
module strobe_merge
  import dbus_responder_pkg::*;
(
  input  word_t      old_word,
  input  word_t      new_word,
  input  logic [7:0] strobe,
  output word_t      merged_word
);

  always_comb begin
    merged_word = old_word;
    for (int k = 0; k < 8; k++) begin
      if (strobe[k]) merged_word[8*k +: 8] = new_word[8*k +: 8];
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// Data-bus responder: fixed-latency valid/addr_ok/data_ok handshake in front of a
// 64-bit word-addressed scratchpad.
//   state | meaning
//   IDLE  | waiting; req_valid is accepted combinationally
//   BUSY  | latency countdown for the latched request
//   DONE  | data_ok cycle; read result presented, write committed on the closing edge
module dbus_responder
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [63:0] req_addr,
  input  logic [2:0]  req_size,
  input  logic [7:0]  req_strobe,
  input  logic [63:0] req_data,
  output logic        resp_addr_ok,
  output logic        resp_data_ok,
  output logic [63:0] resp_data,
  output logic        resp_err
);

  localparam int unsigned     IDX_W     = $clog2(DEPTH_WORDS);
  localparam int unsigned     CNT_W     = $clog2(DBUS_MAX_LATENCY + 1);
  localparam logic [63:0]     MEM_BYTES = 64'(DEPTH_WORDS) * 64'd8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  dbus_rsp_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic [7:0]       strobe_q, strobe_d;
  word_t            wdata_q, wdata_d;
  word_t            rdata_q, rdata_d;
  logic             err_q, err_d;

  word_t            mem [DEPTH_WORDS];

  logic [63:0]      offset;
  logic             in_range;
  logic             txn_err;
  logic [IDX_W-1:0] idx;
  word_t            rd_word;
  word_t            merged_word;
  logic             mem_we;

  // Error is judged on the latched request, so a core that breaks the hold rule cannot corrupt it.
  assign offset   = addr_q - BASE_ADDR;
  assign in_range = (addr_q >= BASE_ADDR) && (offset < MEM_BYTES);
  assign txn_err  = !in_range || !size_aligned(addr_q[2:0], size_q);
  assign idx      = offset[IDX_W+2:3];
  assign rd_word  = mem[idx];

  strobe_merge u_strobe_merge (
    .old_word    (rd_word),
    .new_word    (wdata_q),
    .strobe      (strobe_q),
    .merged_word (merged_word)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    strobe_d     = strobe_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    mem_we       = 1'b0;
    resp_addr_ok = 1'b0;
    resp_data_ok = 1'b0;
    resp_data    = rdata_q;
    resp_err     = err_q;

    case (state_q)
      IDLE: begin
        // Gated by reset so nothing reads as accepted while the block is held in reset.
        resp_addr_ok = req_valid & reset;
        if (req_valid) begin
          addr_d   = req_addr;
          size_d   = req_size;
          strobe_d = req_strobe;
          wdata_d  = req_data;
          cnt_d    = CNT_LOAD;
          state_d  = (LATENCY == 1) ? DONE : BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        resp_data_ok = 1'b1;
        resp_err     = txn_err;
        resp_data    = txn_err ? '0 : rd_word;
        rdata_d      = txn_err ? '0 : rd_word;
        err_d        = txn_err;
        mem_we       = !txn_err && (strobe_q != 8'h00);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      size_q   <= '0;
      strobe_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      size_q   <= size_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Scratchpad contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= merged_word;
  end

endmodule

// File: tb/tb_dbus_responder.sv
// Bench for dbus_responder: queued expectations from a byte-level memory model,
// checked by an independent monitor whenever data_ok is seen.
module tb_dbus_responder;

  localparam logic [63:0] BASE  = 64'h8000_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          NWIN  = 16;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [63:0] req_addr;
  logic [2:0]  req_size;
  logic [7:0]  req_strobe;
  logic [63:0] req_data;
  logic        resp_addr_ok;
  logic        resp_data_ok;
  logic [63:0] resp_data;
  logic        resp_err;

  logic        r1_valid;
  logic [63:0] r1_addr;
  logic [2:0]  r1_size;
  logic [7:0]  r1_strobe;
  logic [63:0] r1_wdata;
  logic        r1_addr_ok;
  logic        r1_data_ok;
  logic [63:0] r1_data;
  logic        r1_err;

  dbus_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_size(req_size), .req_strobe(req_strobe), .req_data(req_data),
    .resp_addr_ok(resp_addr_ok), .resp_data_ok(resp_data_ok),
    .resp_data(resp_data), .resp_err(resp_err)
  );

  dbus_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .LATENCY(1)) u_dut_lat1 (
    .clk(clk), .reset(reset), .req_valid(r1_valid), .req_addr(r1_addr),
    .req_size(r1_size), .req_strobe(r1_strobe), .req_data(r1_wdata),
    .resp_addr_ok(r1_addr_ok), .resp_data_ok(r1_data_ok),
    .resp_data(r1_data), .resp_err(r1_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic        chk_data;
  } want_t;

  want_t       want_q[$];
  logic [63:0] ref_mem [NWIN];
  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  int          acc_cyc = 0;
  logic [63:0] last_data;
  logic        last_err;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic model_err(input logic [63:0] a, input logic [2:0] s);
    if (s > 3'd3) return 1'b1;
    if (a < BASE || a >= BASE + 64'(8 * DEPTH)) return 1'b1;
    if ((a % (64'd1 << s)) != 64'd0) return 1'b1;
    return 1'b0;
  endfunction

  // Compute the expected response from the model, queue it, then run the handshake.
  task automatic do_txn(input logic [63:0] a, input logic [2:0] s, input logic [7:0] st,
                        input logic [63:0] d, input logic check_data);
    want_t w;
    int    idx;
    bit    seen;
    w.err      = model_err(a, s);
    w.data     = 64'd0;
    w.chk_data = check_data;
    if (!w.err) begin
      idx    = int'((a - BASE) >> 3);
      w.data = ref_mem[idx];
      for (int k = 0; k < 8; k++) if (st[k]) ref_mem[idx][8*k +: 8] = d[8*k +: 8];
    end
    want_q.push_back(w);
    @(posedge clk); #1;
    req_addr = a; req_size = s; req_strobe = st; req_data = d; req_valid = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      seen = resp_data_ok;
    end
    if (!seen) begin
      chk("data_ok_timeout", 64'd0, 64'd1);
      if (want_q.size() > 0) void'(want_q.pop_front());
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    want_t w;
    if (reset) begin
      if (resp_addr_ok) acc_cyc = cyc;
      if (resp_addr_ok || resp_data_ok)
        chk("no_overlap", {63'd0, resp_addr_ok & resp_data_ok}, 64'd0);
      if (resp_data_ok) begin
        last_data = resp_data;
        last_err  = resp_err;
        if (want_q.size() == 0) begin
          chk("unexpected_data_ok", 64'd1, 64'd0);
        end else begin
          w = want_q.pop_front();
          chk("latency", 64'(cyc - acc_cyc), 64'(LAT));
          chk("err", {63'd0, resp_err}, {63'd0, w.err});
          if (w.chk_data) chk("data", resp_data, w.data);
        end
      end
    end
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, old3;
    logic [2:0]  s;
    int          kind;

    reset = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_size = '0; req_strobe = '0; req_data = '0;
    r1_valid = 1'b0; r1_addr = '0; r1_size = '0; r1_strobe = '0; r1_wdata = '0;
    #2;
    chk("rst_addr_ok", {63'd0, resp_addr_ok}, 64'd0);
    chk("rst_data_ok", {63'd0, resp_data_ok}, 64'd0);
    chk("rst_data",    resp_data,             64'd0);
    chk("rst_err",     {63'd0, resp_err},     64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Fill the working window so every later read has a known expectation.
    for (int i = 0; i < NWIN; i++)
      do_txn(BASE + 64'(8 * i), 3'd3, 8'hFF, {$urandom, $urandom}, 1'b0);

    do_txn(BASE, 3'd3, 8'h00, 64'd0, 1'b1);

    do_txn(BASE + 64'h8, 3'd3, 8'hFF, 64'h1122_3344_5566_7788, 1'b1);
    do_txn(BASE + 64'h8, 3'd3, 8'h00, 64'd0, 1'b1);
    chk("sd_ld_word1", last_data, 64'h1122_3344_5566_7788);

    do_txn(BASE, 3'd3, 8'hFF, 64'd0, 1'b1);
    do_txn(BASE + 64'h2, 3'd0, 8'h04, 64'h0000_0000_00AB_0000, 1'b1);
    do_txn(BASE, 3'd3, 8'h00, 64'd0, 1'b1);
    chk("sb_lane2", last_data, 64'h0000_0000_00AB_0000);

    do_txn(64'h7FFF_FFF8, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    chk("below_err", {63'd0, last_err}, 64'd1);
    chk("below_data", last_data, 64'd0);
    do_txn(64'h8000_2000, 3'd3, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    chk("above_err", {63'd0, last_err}, 64'd1);
    chk("above_data", last_data, 64'd0);
    do_txn(64'h8000_0006, 3'd2, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    chk("misalign_err", {63'd0, last_err}, 64'd1);
    chk("misalign_data", last_data, 64'd0);
    do_txn(BASE + 64'h8, 3'd3, 8'h00, 64'd0, 1'b1);
    chk("after_err_word1", last_data, 64'h1122_3344_5566_7788);
    chk("after_err_ok", {63'd0, last_err}, 64'd0);

    // Back-to-back on the LATENCY=1 instance: first pass writes, later passes read it back.
    @(posedge clk); #1;
    r1_addr = BASE + 64'h10; r1_size = 3'd3; r1_strobe = 8'hFF;
    r1_wdata = 64'hA5A5_0F0F_1234_5678; r1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("b2b_addr_ok", {63'd0, r1_addr_ok}, {63'd0, (i % 2) == 0});
      chk("b2b_data_ok", {63'd0, r1_data_ok}, {63'd0, (i % 2) == 1});
      if (i % 2 == 1) chk("b2b_err", {63'd0, r1_err}, 64'd0);
      if (i >= 3 && i % 2 == 1) chk("b2b_data", r1_data, 64'hA5A5_0F0F_1234_5678);
    end
    @(posedge clk); #1 r1_valid = 1'b0;

    // Reset during BUSY drops the pending store.
    old3 = ref_mem[3];
    @(posedge clk); #1;
    req_addr = BASE + 64'h18; req_size = 3'd3; req_strobe = 8'hFF;
    req_data = ~old3; req_valid = 1'b1;
    @(negedge clk);
    chk("rst_txn_accept", {63'd0, resp_addr_ok}, 64'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst_addr_ok", {63'd0, resp_addr_ok}, 64'd0);
    chk("midrst_data_ok", {63'd0, resp_data_ok}, 64'd0);
    chk("midrst_data",    resp_data,             64'd0);
    chk("midrst_err",     {63'd0, resp_err},     64'd0);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset = 1'b1;
    do_txn(BASE + 64'h18, 3'd3, 8'h00, 64'd0, 1'b1);
    chk("rst_no_write", last_data, old3);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        case ($urandom_range(0, 3))
          0: begin a = BASE - 64'(8 * $urandom_range(1, 100)); s = 3'd3; end
          1: begin a = BASE + 64'(8 * DEPTH) + 64'(8 * $urandom_range(0, 100)); s = 3'd3; end
          2: begin s = 3'($urandom_range(1, 3)); a = BASE + 64'(8 * $urandom_range(0, NWIN - 1)) + 64'd1; end
          default: begin s = 3'($urandom_range(4, 7)); a = BASE + 64'(8 * $urandom_range(0, NWIN - 1)); end
        endcase
      end else begin
        s = 3'($urandom_range(0, 3));
        a = BASE + 64'(8 * $urandom_range(0, NWIN - 1))
                 + 64'((($urandom_range(0, 7)) >> s) << s);
      end
      do_txn(a, s, ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00,
             {$urandom, $urandom}, 1'b1);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", 64'(want_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
